// File: rtl/sort_pkg.sv
// Shared constants and FSM encoding for the merge sorter tree.
package sort_pkg;

    localparam int W       = 32;
    localparam int RUN_LEN = 16;
    localparam int CNT_W   = 6;

    localparam logic [W-1:0] SENTINEL = '1;

    typedef enum logic {
        MERGE = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/merge_node_fifo2.sv
// Two-entry input buffer; head is always visible on dout, enq+deq when full is legal.
module fifo2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         enq,
    input  logic         deq,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    logic [W-1:0] head_q, tail_q;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_enq, do_deq;

    assign do_deq = deq && (cnt_q != 2'd0);
    assign do_enq = enq && ((cnt_q != 2'd2) || do_deq);

    always_comb begin
        cnt_d = cnt_q;
        case ({do_enq, do_deq})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (do_deq)
                head_q <= tail_q;
            // New word lands in the head slot when the buffer is (or becomes) empty ahead of it.
            if (do_enq) begin
                if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && do_deq))
                    head_q <= din;
                else
                    tail_q <= din;
            end
        end
    end

    assign dout  = head_q;
    assign empty = (cnt_q == 2'd0);
    assign full  = (cnt_q == 2'd2);

endmodule

// File: rtl/merge_node.sv
// 2-to-1 merge cell: merges two ascending sentinel-padded runs into one run of 2*RUN_LEN words.
module merge_node
    import sort_pkg::*;
#(
    parameter int W       = sort_pkg::W,
    parameter int RUN_LEN = sort_pkg::RUN_LEN,
    parameter int CNT_W   = sort_pkg::CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         restart,
    input  logic [W-1:0] a_din,
    input  logic         a_enq,
    output logic         a_full,
    input  logic [W-1:0] b_din,
    input  logic         b_enq,
    output logic         b_full,
    input  logic         full,
    output logic [W-1:0] dout,
    output logic         enq,
    output logic         done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * RUN_LEN);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     dout_q, load_val;
    logic             out_v_q;
    logic             ld, load, pop_a, pop_b;
    logic [W-1:0]     a_head, b_head;
    logic             a_empty, b_empty, a_fifo_full, b_fifo_full;

    fifo2 #(.W(W)) u_fifo_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (restart),
        .enq   (a_enq && !restart),
        .deq   (pop_a),
        .din   (a_din),
        .dout  (a_head),
        .empty (a_empty),
        .full  (a_fifo_full)
    );

    fifo2 #(.W(W)) u_fifo_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (restart),
        .enq   (b_enq && !restart),
        .deq   (pop_b),
        .din   (b_din),
        .dout  (b_head),
        .empty (b_empty),
        .full  (b_fifo_full)
    );

    assign enq = out_v_q && !full && !restart;
    assign ld  = !out_v_q || enq;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pop_a    = 1'b0;
        pop_b    = 1'b0;
        load     = 1'b0;
        load_val = dout_q;
        if (!restart) begin
            case (state_q)
                MERGE: begin
                    if (ld && !a_empty && !b_empty) begin
                        load  = 1'b1;
                        cnt_d = cnt_q + 1'b1;
                        if (a_head <= b_head) begin
                            pop_a    = 1'b1;
                            load_val = a_head;
                        end else begin
                            pop_b    = 1'b1;
                            load_val = b_head;
                        end
                        if (cnt_d == LAST)
                            state_d = FLUSH;
                    end
                end
                FLUSH: begin
                    // Leftover sentinels are drained so upstream never stalls.
                    pop_a = !a_empty;
                    pop_b = !b_empty;
                    if (ld) begin
                        load     = 1'b1;
                        load_val = '1;
                    end
                end
                default: state_d = MERGE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MERGE;
            cnt_q   <= '0;
            out_v_q <= 1'b0;
            dout_q  <= '0;
        end else if (restart) begin
            state_q <= MERGE;
            cnt_q   <= '0;
            out_v_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (ld) begin
                out_v_q <= load;
                if (load)
                    dout_q <= load_val;
            end
        end
    end

    assign a_full = a_fifo_full && !pop_a;
    assign b_full = b_fifo_full && !pop_b;
    assign dout   = dout_q;
    assign done   = (state_q == FLUSH);

endmodule

// File: tb/tb_merge_node.sv
// Directed bench for merge_node: merge order, backpressure, sentinel-valued data, restart and reset.
module tb_merge_node;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        restart;
    logic [31:0] a_din, b_din;
    logic        a_enq, b_enq;
    logic        a_full, b_full;
    logic        full;
    logic [31:0] dout;
    logic        enq;
    logic        done;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0] a_q[$];
    logic [31:0] b_q[$];
    logic [31:0] got[$];
    logic [31:0] exp_q[$];
    logic        full_hold = 1'b0;

    merge_node #(.W(32), .RUN_LEN(16), .CNT_W(6)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .a_din   (a_din),
        .a_enq   (a_enq),
        .a_full  (a_full),
        .b_din   (b_din),
        .b_enq   (b_enq),
        .b_full  (b_full),
        .full    (full),
        .dout    (dout),
        .enq     (enq),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One cycle: set full, collect any output word, offer the next queued inputs.
    task automatic step();
        @(negedge clk);
        full = full_hold;
        #1;
        if (enq) got.push_back(dout);
        a_enq = 1'b0;
        b_enq = 1'b0;
        if (a_q.size() > 0 && !a_full) begin
            a_enq = 1'b1;
            a_din = a_q.pop_front();
        end
        if (b_q.size() > 0 && !b_full) begin
            b_enq = 1'b1;
            b_din = b_q.pop_front();
        end
    endtask

    task automatic run_until(input int n, input int budget);
        int cyc = 0;
        while (got.size() < n && cyc < budget) begin
            step();
            cyc++;
        end
        chk("words_within_budget", 32'(got.size()), 32'(n));
    endtask

    task automatic check_seq(input string tag);
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), (i < got.size()) ? got[i] : 32'hDEADBEEF, exp_q[i]);
    endtask

    // kind 0: odd/even 1..32; kind 1: all fives; kind 2: odd run ending in all-ones word.
    task automatic load_runs(input int kind);
        a_q.delete(); b_q.delete(); exp_q.delete(); got.delete();
        for (int i = 0; i < 16; i++) begin
            case (kind)
                1: begin a_q.push_back(32'd5); b_q.push_back(32'd5); end
                2: begin
                    a_q.push_back((i == 15) ? 32'hFFFF_FFFF : 32'(2 * i + 1));
                    b_q.push_back(32'(2 * i + 2));
                end
                default: begin a_q.push_back(32'(2 * i + 1)); b_q.push_back(32'(2 * i + 2)); end
            endcase
        end
        for (int i = 0; i < 2; i++) begin
            a_q.push_back(32'hFFFF_FFFF);
            b_q.push_back(32'hFFFF_FFFF);
        end
        case (kind)
            1: for (int i = 0; i < 32; i++) exp_q.push_back(32'd5);
            2: begin
                for (int i = 1; i <= 30; i++) exp_q.push_back(32'(i));
                exp_q.push_back(32'd32);
                exp_q.push_back(32'hFFFF_FFFF);
            end
            default: for (int i = 1; i <= 32; i++) exp_q.push_back(32'(i));
        endcase
    endtask

    task automatic do_restart(input logic check_word, input logic [31:0] word);
        @(negedge clk);
        full    = 1'b0;
        restart = 1'b1;
        a_enq   = 1'b1;
        a_din   = 32'd99;
        b_enq   = 1'b1;
        b_din   = 32'd98;
        #1;
        chk("restart_enq_low", {31'd0, enq}, 32'd0);
        if (check_word) chk("restart_dout_word7", dout, word);
        @(posedge clk);
        #1;
        restart = 1'b0;
        a_enq   = 1'b0;
        b_enq   = 1'b0;
        a_q.delete(); b_q.delete(); got.delete();
        chk("post_restart_done", {31'd0, done}, 32'd0);
        chk("post_restart_dout", dout, 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        restart = 1'b0;
        a_din   = '0;
        b_din   = '0;
        a_enq   = 1'b0;
        b_enq   = 1'b0;
        full    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_dout", dout, 32'd0);
        chk("reset_enq", {31'd0, enq}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_a_full", {31'd0, a_full}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Interleaved runs produce 1..32, then sentinels forever.
        load_runs(0);
        run_until(32, 200);
        check_seq("t1");
        chk("t1_done", {31'd0, done}, 32'd1);
        repeat (3) step();
        chk("t1_sentinel_enq", {31'd0, enq}, 32'd1);
        chk("t1_sentinel_dout", dout, 32'hFFFF_FFFF);
        chk("t1_done_held", {31'd0, done}, 32'd1);

        // All-equal runs.
        do_restart(1'b0, 32'd0);
        load_runs(1);
        run_until(32, 200);
        check_seq("t2");
        chk("t2_done", {31'd0, done}, 32'd1);

        // Downstream backpressure for 10 cycles after word 10.
        do_restart(1'b0, 32'd0);
        load_runs(0);
        run_until(10, 100);
        full_hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t3_enq_held_low", {31'd0, enq}, 32'd0);
        end
        chk("t3_dout_stable", dout, 32'd11);
        chk("t3_a_full", {31'd0, a_full}, 32'd1);
        chk("t3_b_full", {31'd0, b_full}, 32'd1);
        chk("t3_count_frozen", 32'(got.size()), 32'd10);
        full_hold = 1'b0;
        run_until(32, 200);
        check_seq("t3");

        // All-ones as real data is the 32nd word; done waits for it.
        do_restart(1'b0, 32'd0);
        load_runs(2);
        run_until(31, 200);
        chk("t4_done_before_last", {31'd0, done}, 32'd0);
        run_until(32, 20);
        chk("t4_done_after_last", {31'd0, done}, 32'd1);
        check_seq("t4");

        // Restart while word 7 is waiting on the output.
        do_restart(1'b0, 32'd0);
        load_runs(0);
        run_until(6, 100);
        do_restart(1'b1, 32'd7);
        load_runs(0);
        run_until(32, 200);
        check_seq("t5");

        // Asynchronous reset mid-run.
        do_restart(1'b0, 32'd0);
        load_runs(0);
        run_until(5, 100);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_dout", dout, 32'd0);
        chk("t6_rst_enq", {31'd0, enq}, 32'd0);
        chk("t6_rst_done", {31'd0, done}, 32'd0);
        a_enq = 1'b0;
        b_enq = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        load_runs(0);
        run_until(32, 200);
        check_seq("t6");

        // B idle: A fills its buffer, nothing is popped or emitted.
        do_restart(1'b0, 32'd0);
        load_runs(0);
        b_q.delete();
        repeat (20) step();
        chk("t6_idle_no_output", 32'(got.size()), 32'd0);
        chk("t6_idle_a_left", 32'(a_q.size()), 32'd16);
        chk("t6_idle_a_full", {31'd0, a_full}, 32'd1);
        chk("t6_idle_enq", {31'd0, enq}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
